uart_matrix_loader: RTL

UART_MATRIX_LOADER -- requirements
Module: uart_matrix_loader

---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/uart_rx_8n1.sv | 97 +++++++++
 rtl/uart_matrix_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART matrix loader and its bit-level receiver.
package uart_loader_pkg;

   localparam int DEFAULT_BAUD_TICKS = 10;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      ERR
   } ldr_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_FRAME   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_BAD_DIM = 2'b11;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling with a down-counting baud timer.
//
// state    | meaning
// RX_IDLE  | waiting for a high-to-low edge on the synchronized line
// RX_START | half-bit wait, then start bit re-checked (high = glitch)
// RX_DATA  | eight data bits sampled LSB-first, one per bit period
// RX_STOP  | stop bit sampled; 1 = byte_valid, 0 = frame_err
module uart_rx_8n1
   import uart_loader_pkg::*;
#(
   parameter int BAUD_TICKS = DEFAULT_BAUD_TICKS
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rx_in,
   output logic [7:0] byte_out,
   output logic       byte_valid_out,
   output logic       frame_err_out
);

   localparam int CW = $clog2(BAUD_TICKS);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_TICKS / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_TICKS - 1);

   logic            sync1_q, sync2_q, prev_q;
   rx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tick;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync1_q <= rx_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   assign tick = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = cnt_q;
            if (prev_q && !sync2_q) begin
               state_d = RX_START;
               cnt_d   = HALF_LOAD;
            end
         end
         RX_START: begin
            if (tick) begin
               if (!sync2_q) begin
                  state_d = RX_DATA;
                  cnt_d   = FULL_LOAD;
                  bit_d   = '0;
               end else begin
                  state_d = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               shift_d = {sync2_q, shift_q[7:1]};
               cnt_d   = FULL_LOAD;
               if (bit_q == 3'd7) state_d = RX_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (tick) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign byte_out       = shift_q;
   assign byte_valid_out = (state_q == RX_STOP) && tick && sync2_q;
   assign frame_err_out  = (state_q == RX_STOP) && tick && !sync2_q;

endmodule

// File: rtl/uart_matrix_loader.sv
// Loads two NxN matrices (A then B) of little-endian multi-byte elements from a UART stream.
//
// state  | meaning
// IDLE   | waiting for start_in; received bytes discarded
// LOAD_A | assembling and writing matrix A elements, row-major
// LOAD_B | assembling and writing matrix B elements, row-major
// ERR    | load aborted, err_out high, waiting for the next valid start
module uart_matrix_loader
   import uart_loader_pkg::*;
#(
   parameter int BAUD_TICKS    = DEFAULT_BAUD_TICKS,
   parameter int ELEM_BYTES    = 4,
   parameter int MAX_DIM       = 4,
   parameter int TIMEOUT_TICKS = 64 * BAUD_TICKS
) (
   input  logic                                           clk_in,
   input  logic                                           rst_in,
   input  logic                                           rx_in,
   input  logic                                           start_in,
   input  logic [$clog2(MAX_DIM+1)-1:0]                   dim_in,
   output logic                                           busy_out,
   output logic                                           done_out,
   output logic                                           err_out,
   output logic [1:0]                                     err_code_out,
   output logic                                           wr_en_out,
   output logic                                           wr_mat_out,
   output logic [((MAX_DIM > 1) ? $clog2(MAX_DIM) : 1)-1:0] wr_row_out,
   output logic [((MAX_DIM > 1) ? $clog2(MAX_DIM) : 1)-1:0] wr_col_out,
   output logic [8*ELEM_BYTES-1:0]                        wr_data_out
);

   localparam int DIM_W  = $clog2(MAX_DIM + 1);
   localparam int RC_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
   localparam int DATA_W = 8 * ELEM_BYTES;
   localparam int BC_W   = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
   localparam int TO_W   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TO_W-1:0] TO_LOAD   = TO_W'(TIMEOUT_TICKS - 1);
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(ELEM_BYTES - 1);

   logic [7:0]        rx_byte;
   logic              rx_valid, rx_frame_err;

   ldr_state_t        state_q, state_d;
   logic [DIM_W-1:0]  dim_q, dim_d;
   logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [DATA_W-1:0] elem_buf_q, elem_buf_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              done_q, done_d;
   logic              wr_en_q, wr_en_d;
   logic              wr_last_q, wr_last_d;
   logic              wr_mat_q, wr_mat_d;
   logic [RC_W-1:0]   wr_row_q, wr_row_d, wr_col_q, wr_col_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic              dim_ok;
   logic [DIM_W-1:0]  last_idx;
   logic [DATA_W-1:0] merged;

   uart_rx_8n1 #(
      .BAUD_TICKS(BAUD_TICKS)
   ) u_rx (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rx_in         (rx_in),
      .byte_out      (rx_byte),
      .byte_valid_out(rx_valid),
      .frame_err_out (rx_frame_err)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         dim_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         byte_cnt_q <= '0;
         elem_buf_q <= '0;
         to_cnt_q   <= '0;
         err_code_q <= ERR_NONE;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_last_q  <= 1'b0;
         wr_mat_q   <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         dim_q      <= dim_d;
         row_q      <= row_d;
         col_q      <= col_d;
         byte_cnt_q <= byte_cnt_d;
         elem_buf_q <= elem_buf_d;
         to_cnt_q   <= to_cnt_d;
         err_code_q <= err_code_d;
         done_q     <= done_d;
         wr_en_q    <= wr_en_d;
         wr_last_q  <= wr_last_d;
         wr_mat_q   <= wr_mat_d;
         wr_row_q   <= wr_row_d;
         wr_col_q   <= wr_col_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign dim_ok   = (dim_in != '0) && (dim_in <= DIM_W'(MAX_DIM));
   assign last_idx = dim_q - DIM_W'(1);

   // Current element with the incoming byte dropped into its little-endian slot.
   always_comb begin
      merged = elem_buf_q;
      merged[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
   end

   always_comb begin
      state_d    = state_q;
      dim_d      = dim_q;
      row_d      = row_q;
      col_d      = col_q;
      byte_cnt_d = byte_cnt_q;
      elem_buf_d = elem_buf_q;
      to_cnt_d   = to_cnt_q;
      err_code_d = err_code_q;
      done_d     = 1'b0;
      wr_en_d    = 1'b0;
      wr_last_d  = 1'b0;
      wr_mat_d   = wr_mat_q;
      wr_row_d   = wr_row_q;
      wr_col_d   = wr_col_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         IDLE, ERR: begin
            if (start_in) begin
               if (dim_ok) begin
                  state_d    = LOAD_A;
                  dim_d      = dim_in;
                  err_code_d = ERR_NONE;
                  row_d      = '0;
                  col_d      = '0;
                  byte_cnt_d = '0;
                  elem_buf_d = '0;
                  to_cnt_d   = TO_LOAD;
               end else begin
                  state_d    = ERR;
                  err_code_d = ERR_BAD_DIM;
               end
            end
         end
         LOAD_A, LOAD_B: begin
            if (rx_frame_err) begin
               state_d    = ERR;
               err_code_d = ERR_FRAME;
            end else if (rx_valid) begin
               to_cnt_d = TO_LOAD;
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  elem_buf_d = '0;
                  wr_en_d    = 1'b1;
                  wr_last_d  = (row_q == last_idx) && (col_q == last_idx);
                  wr_mat_d   = (state_q == LOAD_B);
                  wr_row_d   = row_q[RC_W-1:0];
                  wr_col_d   = col_q[RC_W-1:0];
                  wr_data_d  = merged;
                  if (col_q == last_idx) begin
                     col_d = '0;
                     row_d = (row_q == last_idx) ? '0 : row_q + DIM_W'(1);
                  end else begin
                     col_d = col_q + DIM_W'(1);
                  end
               end else begin
                  elem_buf_d = merged;
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end else if (wr_en_q && wr_last_q) begin
               // Matrix complete: advance the cycle after its final write strobe.
               if (state_q == LOAD_A) begin
                  state_d = LOAD_B;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else if (to_cnt_q == '0) begin
               state_d    = ERR;
               err_code_d = ERR_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q - TO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_out     = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign err_out      = (state_q == ERR);
   assign done_out     = done_q;
   assign err_code_out = err_code_q;
   assign wr_en_out    = wr_en_q;
   assign wr_mat_out   = wr_mat_q;
   assign wr_row_out   = wr_row_q;
   assign wr_col_out   = wr_col_q;
   assign wr_data_out  = wr_data_q;

endmodule
